// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table response capture block.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2
  } tt_state_e;

  localparam int unsigned       ERR_W   = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  // Number of rows in the truth table of an n-input function.
  function automatic int unsigned tt_width(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/tt_response_capture_if.sv
// Vector handshake plus the DUT output being observed.
interface tt_response_capture_if #(
  parameter int N_IN = 3
) ();

  logic            vec_valid;
  logic            vec_ready;
  logic [N_IN-1:0] vec;
  logic            y;

  // Stimulus side: presents vectors and carries the DUT response.
  modport master (
    output vec_valid,
    output vec,
    output y,
    input  vec_ready
  );

  // Capture side.
  modport slave (
    input  vec_valid,
    input  vec,
    input  y,
    output vec_ready
  );

endinterface

// File: rtl/tt_settle_timer.sv
// Down-counter that measures the settle delay between vector acceptance and sampling.
module tt_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int          W        = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int unsigned LOAD_INT = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [W-1:0] LOAD_VAL = LOAD_INT[W-1:0];

  logic [W-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of its inputs regardless of block order.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/tt_response_capture.sv
// Accepts applied input vectors, waits for the DUT to settle, samples its output
// and builds the observed truth table, coverage and mismatch statistics.
module tt_response_capture
  import tt_pkg::*;
#(
  parameter int                        N_IN   = 3,
  parameter int                        SETTLE = 2,
  parameter logic [tt_width(N_IN)-1:0] EXP_TT = 8'hE8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  tt_response_capture_if.slave      vif,
  output logic [tt_width(N_IN)-1:0] obs_tt,
  output logic [tt_width(N_IN)-1:0] cov,
  output logic [ERR_W-1:0]          err_count,
  output logic                      mismatch_pulse,
  output logic                      inconsistent,
  output logic                      done,
  output logic                      pass
);

  tt_state_e       state_q, state_d;
  logic [N_IN-1:0] idx_q;
  logic            ready;
  logic            accept;
  logic            tmr_load;
  logic            tmr_dec;
  logic            tmr_zero;
  logic            sample_en;
  logic            y_mismatch;
  logic            y_clash;

  tt_settle_timer #(
    .SETTLE(SETTLE)
  ) u_settle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .load  (tmr_load),
    .dec   (tmr_dec),
    .zero  (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default before the case statement,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    accept   = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (vif.vec_valid) begin
          accept = 1'b1;
          if (SETTLE == 0) begin
            state_d = SAMPLE;
          end else begin
            state_d  = WAIT;
            tmr_load = 1'b1;
          end
        end
      end
      WAIT: begin
        if (tmr_zero) begin
          state_d = SAMPLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      SAMPLE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign vif.vec_ready = ready;

  // NOTE: idx_q is a pure datapath register that is always written before it
  // is read (accept precedes SAMPLE), so it deliberately has no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q <= vif.vec;
    end
  end

  assign sample_en  = (state_q == SAMPLE);
  assign y_mismatch = (vif.y != EXP_TT[idx_q]);
  assign y_clash    = cov[idx_q] && (obs_tt[idx_q] != vif.y);

  // Table, coverage and statistics; a clear drops any in-flight vector unrecorded.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      obs_tt         <= '0;
      cov            <= '0;
      err_count      <= '0;
      mismatch_pulse <= 1'b0;
      inconsistent   <= 1'b0;
    end else begin
      mismatch_pulse <= 1'b0;
      if (sample_en) begin
        obs_tt[idx_q]  <= vif.y;
        cov[idx_q]     <= 1'b1;
        mismatch_pulse <= y_mismatch;
        if (y_mismatch && (err_count != ERR_MAX)) begin
          err_count <= err_count + 1'b1;
        end
        if (y_clash) begin
          inconsistent <= 1'b1;
        end
      end
    end
  end

  assign done = &cov;
  assign pass = done && (obs_tt == EXP_TT) && !inconsistent;

endmodule

// File: tb/tb_tt_response_capture.sv
// Directed self-checking bench for tt_response_capture (N_IN=3, SETTLE=2, majority table).
module tb_tt_response_capture;

  localparam int N_IN   = 3;
  localparam int SETTLE = 2;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [7:0] obs_tt;
  logic [7:0] cov;
  logic [7:0] err_count;
  logic       mismatch_pulse;
  logic       inconsistent;
  logic       done;
  logic       pass;

  int checks = 0;
  int errors = 0;

  tt_response_capture_if #(.N_IN(N_IN)) vif ();

  tt_response_capture #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE),
    .EXP_TT (8'hE8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (clear),
    .vif            (vif),
    .obs_tt         (obs_tt),
    .cov            (cov),
    .err_count      (err_count),
    .mismatch_pulse (mismatch_pulse),
    .inconsistent   (inconsistent),
    .done           (done),
    .pass           (pass)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic maj(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  task automatic do_reset();
    rst_n         = 1'b0;
    clear         = 1'b0;
    vif.vec_valid = 1'b0;
    vif.vec       = '0;
    vif.y         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Apply one vector with a constant response; returns #1 after the sample edge.
  task automatic apply(input logic [2:0] v, input logic yv);
    int t = 0;
    while (!vif.vec_ready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!vif.vec_ready) check("ready_timeout", {31'd0, vif.vec_ready}, 32'd1);
    vif.vec_valid = 1'b1;
    vif.vec       = v;
    vif.y         = yv;
    @(posedge clk);
    #1;
    vif.vec_valid = 1'b0;
    repeat (SETTLE + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    int n_acc;
    int last_acc;
    int gap_bad;
    int cyc;

    // Reset values
    do_reset();
    check("rst_obs_tt", obs_tt, 8'h00);
    check("rst_cov", cov, 8'h00);
    check("rst_err_count", err_count, 8'd0);
    check("rst_mismatch_pulse", mismatch_pulse, 1'b0);
    check("rst_inconsistent", inconsistent, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_vec_ready", vif.vec_ready, 1'b1);

    // Full in-order sweep with correct majority responses
    for (int i = 0; i < 8; i++) begin
      apply(3'(i), maj(3'(i)));
      check("sweep_pulse", mismatch_pulse, 1'b0);
      if (i == 6) check("sweep_done_early", done, 1'b0);
    end
    check("sweep_obs_tt", obs_tt, 8'hE8);
    check("sweep_cov", cov, 8'hFF);
    check("sweep_err_count", err_count, 8'd0);
    check("sweep_done", done, 1'b1);
    check("sweep_pass", pass, 1'b1);

    // Single wrong response on vector 101
    do_reset();
    apply(3'b101, 1'b0);
    check("single_pulse_hi", mismatch_pulse, 1'b1);
    check("single_cov", cov, 8'h20);
    check("single_obs_tt", obs_tt, 8'h00);
    check("single_err_count", err_count, 8'd1);
    check("single_done", done, 1'b0);
    @(posedge clk);
    #1;
    check("single_pulse_lo", mismatch_pulse, 1'b0);

    // y changes late in the settle window; only the sample edge counts
    do_reset();
    vif.vec_valid = 1'b1;
    vif.vec       = 3'b011;
    vif.y         = 1'b0;
    @(posedge clk);                       // edge k: accept
    #1;
    vif.vec_valid = 1'b0;
    check("settle_ready_k1", vif.vec_ready, 1'b0);
    @(posedge clk);
    #1;
    check("settle_ready_k2", vif.vec_ready, 1'b0);
    @(posedge clk);
    #1;
    check("settle_ready_k3", vif.vec_ready, 1'b0);
    vif.y = 1'b1;
    @(posedge clk);                       // edge k+3: sample
    #1;
    check("settle_ready_back", vif.vec_ready, 1'b1);
    check("settle_obs_tt", obs_tt, 8'h08);
    check("settle_cov", cov, 8'h08);
    check("settle_err_count", err_count, 8'd0);
    check("settle_pulse", mismatch_pulse, 1'b0);
    vif.vec_valid = 1'b1;
    vif.vec       = 3'b000;
    vif.y         = 1'b0;
    @(posedge clk);                       // edge k+4: second accept
    #1;
    vif.vec_valid = 1'b0;
    check("settle_reaccept", vif.vec_ready, 1'b0);
    repeat (SETTLE + 1) @(posedge clk);
    #1;
    check("settle_cov2", cov, 8'h09);

    // Same vector sampled twice with different responses
    do_reset();
    apply(3'b010, 1'b0);
    check("incons_first", inconsistent, 1'b0);
    apply(3'b010, 1'b1);
    check("incons_set", inconsistent, 1'b1);
    for (int i = 0; i < 8; i++) apply(3'(i), maj(3'(i)));
    check("incons_obs_tt", obs_tt, 8'hE8);
    check("incons_err_count", err_count, 8'd1);
    check("incons_done", done, 1'b1);
    check("incons_pass", pass, 1'b0);
    check("incons_sticky", inconsistent, 1'b1);

    // Clear during WAIT discards the in-flight vector
    do_reset();
    vif.vec_valid = 1'b1;
    vif.vec       = 3'b111;
    vif.y         = 1'b0;
    @(posedge clk);
    #1;
    vif.vec_valid = 1'b0;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clear_idle", vif.vec_ready, 1'b1);
    check("clear_cov", cov, 8'h00);
    check("clear_err_count", err_count, 8'd0);
    check("clear_obs_tt", obs_tt, 8'h00);
    repeat (4) @(posedge clk);
    #1;
    check("clear_no_sample_cov", cov, 8'h00);
    check("clear_no_sample_err", err_count, 8'd0);

    // 300 back-to-back wrong samples: saturation and throughput
    do_reset();
    vif.vec_valid = 1'b1;
    vif.vec       = 3'b111;
    vif.y         = 1'b0;
    n_acc    = 0;
    last_acc = -1;
    gap_bad  = 0;
    cyc      = 0;
    while (n_acc < 300 && cyc < 2000) begin
      if (vif.vec_ready) begin
        if (last_acc >= 0 && (cyc - last_acc) != SETTLE + 2) gap_bad++;
        last_acc = cyc;
        n_acc++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    vif.vec_valid = 1'b0;
    repeat (SETTLE + 1) @(posedge clk);
    #1;
    check("sat_accepts", n_acc, 300);
    check("sat_gap_bad", gap_bad, 0);
    check("sat_err_count", err_count, 8'd255);
    check("sat_cov", cov, 8'h80);
    check("sat_inconsistent", inconsistent, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
